step_clock_gen: RTL and testbench
=================================

STEP_CLOCK_GEN -- requirements
Module: step_clock_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable samples required to accept a new button level.
REQ-002 Parameter HIGH_CYCLES, default 25000: clk_fpga cycles cpu_clock stays high per single-step pulse.
REQ-003 Parameter RUN_HALF_PERIOD, default 25000000: clk_fpga cycles per half period in free-run mode.
REQ-004 Parameter COUNT_WIDTH, default 16: width of the edge counter.
REQ-005 clk_fpga  input  1  board clock; all logic on its rising edge; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 button_n  input  1  raw asynchronous push-button, active-low (pressed = 0).
REQ-008 run_mode  input  1  raw asynchronous switch; 1 = free-run, 0 = single-step.
REQ-009 cpu_clock  output  1  registered clock level driven to the processor.
REQ-010 step_pulse  output  1  one-cycle strobe on each accepted press.
REQ-011 button_level  output  1  debounced button, active-high (1 = pressed).
REQ-012 edge_count  output  COUNT_WIDTH  number of cpu_clock rising edges since reset.

Function
REQ-013 button_n and run_mode SHALL each pass through a two-flop synchronizer before any other use.
REQ-014 Debounce counter SHALL reset to 0 whenever the synchronized button differs from button_level, and increment otherwise.
REQ-015 button_level SHALL adopt the synchronized level in the cycle the counter reaches DEBOUNCE_CYCLES-1 while differing; glitches shorter than DEBOUNCE_CYCLES SHALL never change it.
REQ-016 step_pulse SHALL be high for exactly the one cycle after button_level rises 0->1; releases produce no pulse.
REQ-017 FSM states SHALL be IDLE, STEP_HIGH, RUN_HIGH, RUN_LOW; cpu_clock = 1 only in STEP_HIGH and RUN_HIGH.
REQ-018 IDLE: if synchronized run_mode = 1 go to RUN_HIGH; else if step_pulse go to STEP_HIGH; else stay.
REQ-019 STEP_HIGH SHALL last exactly HIGH_CYCLES cycles, then return to IDLE.
REQ-020 RUN_HIGH and RUN_LOW SHALL each last exactly RUN_HALF_PERIOD cycles, alternating.
REQ-021 Leaving free-run: run_mode = 0 SHALL be honoured only at the end of RUN_LOW (go to IDLE); no truncated high phase.
REQ-022 Step presses during STEP_HIGH, RUN_HIGH or RUN_LOW SHALL be ignored (not queued).
REQ-023 run_mode = 1 asserted during STEP_HIGH SHALL take effect only after STEP_HIGH completes (IDLE, then RUN_HIGH).
REQ-024 edge_count SHALL increment by 1 on every entry into STEP_HIGH or RUN_HIGH, wrapping from 2^COUNT_WIDTH-1 to 0.
REQ-025 Phase counter SHALL be wide enough for max(HIGH_CYCLES, RUN_HALF_PERIOD); all outputs registered.

Reset
REQ-026 While reset is high at a clk_fpga edge: state = IDLE, cpu_clock = 0, step_pulse = 0, button_level = 0, edge_count = 0, all counters and synchronizer flops = 0 (button_n synchronizer = 1, i.e. released).
REQ-027 Reset asserted mid-phase SHALL force cpu_clock low on the next edge; first behaviour after release is from IDLE.

Structure
REQ-028 State encoding and default parameter values SHALL live in the shared processor package.
REQ-029 Debounce logic SHALL be one sub-module, button_debouncer (synchronizer, counter, level, rising strobe), instantiated once for button_n; run_mode uses only a synchronizer.

Verification (DEBOUNCE_CYCLES=4, HIGH_CYCLES=3, RUN_HALF_PERIOD=5, COUNT_WIDTH=4)
REQ-030 Button low for 10 cycles in step mode -> one step_pulse, cpu_clock high exactly 3 cycles, edge_count = 1.
REQ-031 Button low 3-cycle glitch -> button_level stays 0, no step_pulse, cpu_clock stays 0.
REQ-032 run_mode = 1 for 40 cycles -> cpu_clock square wave 5 high / 5 low; clear run_mode in a high phase -> high and low phases complete, then IDLE.
REQ-033 Second press accepted during STEP_HIGH -> ignored; edge_count increments once only.
REQ-034 17 step presses -> edge_count wraps to 1.
REQ-035 Reset asserted in RUN_HIGH -> next edge cpu_clock = 0, edge_count = 0, state IDLE.

Source files
------------

// File: rtl/step_clock_gen_pkg.sv
// Shared definitions for the single-step / free-run processor clock generator:
// FSM state encoding, default timing parameters and a small sizing helper.
package step_clock_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STEP_HIGH = 2'd1,
    RUN_HIGH  = 2'd2,
    RUN_LOW   = 2'd3
  } clk_state_e;

  localparam int DEF_DEBOUNCE_CYCLES  = 50000;
  localparam int DEF_HIGH_CYCLES      = 25000;
  localparam int DEF_RUN_HALF_PERIOD  = 25000000;
  localparam int DEF_COUNT_WIDTH      = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_clock_gen_button.sv
// button_debouncer: two-flop synchronizer, stability counter, debounced level
// and a one-cycle strobe on each accepted press (0->1 of the level).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit SYNC_RESET_VAL  = 1'b1,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sample_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  assign sample_s = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // The counter only runs while a change is pending; a single agreeing sample
  // clears it, so shorter glitches can never reach the acceptance point.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sample_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sample_s;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= {2{SYNC_RESET_VAL}};
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/step_clock_gen.sv
// Processor clock source: one fixed-width high pulse per debounced button press
// in single-step mode, or a continuous square wave in free-run mode.
module step_clock_gen
  import step_clock_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HIGH_CYCLES     = DEF_HIGH_CYCLES,
  parameter int RUN_HALF_PERIOD = DEF_RUN_HALF_PERIOD,
  parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
  input  logic                   clk_fpga,
  input  logic                   reset,
  input  logic                   button_n,
  input  logic                   run_mode,
  output logic                   cpu_clock,
  output logic                   step_pulse,
  output logic                   button_level,
  output logic [COUNT_WIDTH-1:0] edge_count
);

  localparam int PHASE_MAX = max_int(HIGH_CYCLES, RUN_HALF_PERIOD);
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_CYCLES - 1);
  localparam logic [PW-1:0] RUN_LAST  = PW'(RUN_HALF_PERIOD - 1);

  clk_state_e             state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [1:0]             run_sync_q;
  logic                   run_s;
  logic                   cpu_clock_q, cpu_clock_d;
  logic [COUNT_WIDTH-1:0] edge_count_q, edge_count_d;
  logic                   enter_high_s;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_RESET_VAL  (1'b1),
    .ACTIVE_LOW      (1'b1)
  ) u_button (
    .clk_i   (clk_fpga),
    .reset_i (reset),
    .raw_i   (button_n),
    .level_o (button_level),
    .rise_o  (step_pulse)
  );

  assign run_s = run_sync_q[1];

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      run_sync_q <= 2'b00;
    end else begin
      run_sync_q <= {run_sync_q[0], run_mode};
    end
  end

  // Presses are only looked at in IDLE, so strobes during any high or low
  // phase are dropped; run_mode is only re-checked at phase boundaries.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (run_s) begin
          state_d = RUN_HIGH;
        end else if (step_pulse) begin
          state_d = STEP_HIGH;
        end else begin
          state_d = IDLE;
        end
      end
      STEP_HIGH: begin
        if (phase_q == HIGH_LAST) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      RUN_HIGH: begin
        if (phase_q == RUN_LAST) begin
          state_d = RUN_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      RUN_LOW: begin
        if (phase_q == RUN_LAST) begin
          phase_d = '0;
          if (run_s) begin
            state_d = RUN_HIGH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    cpu_clock_d  = (state_d == STEP_HIGH) || (state_d == RUN_HIGH);
    enter_high_s = cpu_clock_d && (state_d != state_q);
    if (enter_high_s) begin
      edge_count_d = edge_count_q + COUNT_WIDTH'(1);
    end else begin
      edge_count_d = edge_count_q;
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      cpu_clock_q  <= 1'b0;
      edge_count_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cpu_clock_q  <= cpu_clock_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign cpu_clock  = cpu_clock_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Self-checking bench for step_clock_gen: a scoreboard of expected cpu_clock
// high pulses (length, edge_count at the rise) plus per-scenario inline checks.
module tb_step_clock_gen;

  typedef struct {
    int         len;
    logic [3:0] cnt;
  } exp_t;

  logic       clk_fpga = 1'b0;
  logic       reset    = 1'b1;
  logic       button_n = 1'b1;
  logic       run_mode = 1'b0;
  logic       cpu_clock, step_pulse, button_level;
  logic [3:0] edge_count;
  logic       l_cpu_clock, l_step_pulse, l_button_level;
  logic [3:0] l_edge_count;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] model_cnt = 4'd0;
  int         sp_cnt;
  bit         lvl_seen, cpu_seen;
  bit         in_pulse = 1'b0;
  int         hi_len = 0;
  logic [3:0] snap_cnt = 4'd0;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(4), .HIGH_CYCLES(3), .RUN_HALF_PERIOD(5), .COUNT_WIDTH(4)
  ) dut (
    .clk_fpga(clk_fpga), .reset(reset), .button_n(button_n), .run_mode(run_mode),
    .cpu_clock(cpu_clock), .step_pulse(step_pulse), .button_level(button_level),
    .edge_count(edge_count)
  );

  // Long step pulse so a second press can land inside STEP_HIGH.
  step_clock_gen #(
    .DEBOUNCE_CYCLES(4), .HIGH_CYCLES(30), .RUN_HALF_PERIOD(5), .COUNT_WIDTH(4)
  ) dut_long (
    .clk_fpga(clk_fpga), .reset(reset), .button_n(button_n), .run_mode(run_mode),
    .cpu_clock(l_cpu_clock), .step_pulse(l_step_pulse), .button_level(l_button_level),
    .edge_count(l_edge_count)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic push_exp(input int len);
    exp_t e;
    model_cnt = model_cnt + 4'd1;
    e.len = len;
    e.cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic clear_seen();
    sp_cnt   = 0;
    lvl_seen = 1'b0;
    cpu_seen = 1'b0;
  endtask

  // Advance to the next falling edge and run the pulse scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk_fpga);
    if (step_pulse)   sp_cnt++;
    if (button_level) lvl_seen = 1'b1;
    if (cpu_clock)    cpu_seen = 1'b1;
    if (reset) begin
      in_pulse = 1'b0;
    end else if (cpu_clock) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        hi_len   = 1;
        snap_cnt = edge_count;
      end else begin
        hi_len++;
      end
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected: got len=%0d count=%0d, required no pulse", hi_len, snap_cnt);
      end else begin
        e = exp_q.pop_front();
        if (hi_len !== e.len || snap_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL pulse_shape: got len=%0d count=%0d, required len=%0d count=%0d",
                   hi_len, snap_cnt, e.len, e.cnt);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int low_cycles, input int high_cycles);
    button_n = 1'b0;
    ticks(low_cycles);
    button_n = 1'b1;
    ticks(high_cycles);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ticks(3);
    n_checks += 4;
    if (cpu_clock !== 1'b0)    begin n_fail++; $display("FAIL reset_cpu_clock: got %b, required 0", cpu_clock); end
    if (step_pulse !== 1'b0)   begin n_fail++; $display("FAIL reset_step_pulse: got %b, required 0", step_pulse); end
    if (button_level !== 1'b0) begin n_fail++; $display("FAIL reset_button_level: got %b, required 0", button_level); end
    if (edge_count !== 4'd0)   begin n_fail++; $display("FAIL reset_edge_count: got %0d, required 0", edge_count); end
    reset = 1'b0;
    ticks(2);
  endtask

  task automatic test_glitch();
    clear_seen();
    press(3, 15);
    n_checks += 3;
    if (lvl_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_level: got level high, required stay 0"); end
    if (sp_cnt != 0)       begin n_fail++; $display("FAIL glitch_pulse: got %0d pulses, required 0", sp_cnt); end
    if (cpu_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_cpu_clock: got high, required stay 0"); end
  endtask

  task automatic test_single_step();
    clear_seen();
    push_exp(3);
    press(10, 15);
    n_checks += 3;
    if (sp_cnt != 1)         begin n_fail++; $display("FAIL step_pulse_count: got %0d, required 1", sp_cnt); end
    if (lvl_seen !== 1'b1)   begin n_fail++; $display("FAIL step_level: got never high, required high"); end
    if (edge_count !== 4'd1) begin n_fail++; $display("FAIL step_edge_count: got %0d, required 1", edge_count); end
  endtask

  // Run free-running for n_high high phases, optionally pressing the button
  // during the run, clearing run_mode two cycles into the last high phase.
  task automatic run_burst(input int n_high, input bit do_press, input string tag);
    int rises = 0, hi = 0, lo = 0, press_t = 0;
    bit prev = 1'b0;
    for (int i = 0; i < n_high; i++) push_exp(5);
    run_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (cpu_clock && !prev) begin
        rises++;
        if (rises > 1) begin
          n_checks++;
          if (lo != 5) begin n_fail++; $display("FAIL %s_low_phase: got %0d cycles, required 5", tag, lo); end
        end
        hi = 0;
      end
      if (!cpu_clock && prev) lo = 0;
      if (cpu_clock) hi++; else lo++;
      if (rises == n_high && hi == 2) run_mode = 1'b0;
      if (do_press && rises >= 1 && press_t < 10) begin
        button_n = 1'b0;
        press_t++;
      end else begin
        button_n = 1'b1;
      end
      prev = cpu_clock;
    end
    n_checks += 2;
    if (rises != n_high) begin n_fail++; $display("FAIL %s_rises: got %0d, required %0d", tag, rises, n_high); end
    if (edge_count !== model_cnt) begin n_fail++; $display("FAIL %s_edge_count: got %0d, required %0d", tag, edge_count, model_cnt); end
  endtask

  task automatic test_free_run();
    run_burst(4, 1'b0, "run");
  endtask

  task automatic test_ignore_during_run();
    clear_seen();
    run_burst(3, 1'b1, "run_press");
    n_checks++;
    if (sp_cnt != 1) begin n_fail++; $display("FAIL run_press_strobe: got %0d, required 1", sp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] l_before;
    ticks(40);
    l_before = l_edge_count;
    clear_seen();
    push_exp(3);
    push_exp(3);
    press(8, 8);
    press(8, 50);
    n_checks += 3;
    if (l_edge_count !== 4'(l_before + 4'd1)) begin
      n_fail++; $display("FAIL b2b_long_edge_count: got %0d, required %0d", l_edge_count, 4'(l_before + 4'd1));
    end
    if (edge_count !== model_cnt) begin n_fail++; $display("FAIL b2b_edge_count: got %0d, required %0d", edge_count, model_cnt); end
    if (sp_cnt != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d, required 2", sp_cnt); end
  endtask

  task automatic test_reset_mid_run();
    int waited = 0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pre_reset_queue: got %0d pending, required 0", exp_q.size()); end
    run_mode = 1'b1;
    while (!cpu_clock && waited < 50) begin tick(); waited++; end
    n_checks++;
    if (!cpu_clock) begin n_fail++; $display("FAIL rst_run_start: got no high phase, required one within 50 cycles"); end
    ticks(2);
    reset = 1'b1;
    tick();
    model_cnt = 4'd0;
    n_checks += 3;
    if (cpu_clock !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_cpu_clock: got %b, required 0", cpu_clock); end
    if (edge_count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_edge_count: got %0d, required 0", edge_count); end
    if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_mid_step_pulse: got %b, required 0", step_pulse); end
    run_mode = 1'b0;
    tick();
    reset = 1'b0;
    clear_seen();
    ticks(12);
    n_checks++;
    if (cpu_seen !== 1'b0) begin n_fail++; $display("FAIL rst_release_idle: got cpu_clock high, required IDLE"); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      push_exp(3);
      press(8, 8);
    end
    ticks(5);
    n_checks++;
    if (edge_count !== 4'd1) begin n_fail++; $display("FAIL wrap_edge_count: got %0d, required 1", edge_count); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_step();
    test_free_run();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_wrap();
    ticks(5);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_pulses: got %0d missing, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
